flash_img_reader: RTL and testbench

FLASH_IMG_READER -- requirements
Module: flash_img_reader

---
 rtl/vga_flash_pkg.sv | 19 +
 rtl/flash_img_reader.sv | 117 +++++++++++
 tb/tb_flash_img_reader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_flash_pkg.sv
// Shared definitions for the VGA image loader and its parallel NOR flash port:
// FSM encoding, default access length and flash pin tie-off levels.
package vga_flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 4;

    // Pins that never change: out of reset, 16-bit bus, programming disabled.
    localparam logic FLASH_RP_N_TIE   = 1'b1;
    localparam logic FLASH_BYTE_N_TIE = 1'b1;
    localparam logic FLASH_VPEN_TIE   = 1'b0;
    localparam logic FLASH_WE_N_TIE   = 1'b1;

endpackage

// File: rtl/flash_img_reader.sv
// Read-only word fetcher from parallel NOR flash for the VGA image loader.
// Handshake: the consumer holds vga_re=1 with a byte address; vga_success=1 means vga_data holds the word at that address, and moving the address requests the next word.
module flash_img_reader
    import vga_flash_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_re,
    input  logic [22:0] vga_addr,
    output logic [15:0] vga_data,
    output logic        vga_success,
    output logic [22:0] flash_a,
    inout  wire  [15:0] flash_d,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        flash_rp_n,
    output logic        flash_byte_n,
    output logic        flash_vpen,
    output state_t      dbg_state
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] data_d;
    logic        success_d;
    logic        strobe_n_d;
    logic [22:0] req_addr;
    logic        addr_moved;

    // Word-align the request; bit 0 only selects a byte the consumer picks itself.
    assign req_addr   = vga_addr & ~23'd1;
    assign addr_moved = (req_addr != addr_q);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        addr_d     = addr_q;
        data_d     = vga_data;
        success_d  = vga_success;
        strobe_n_d = 1'b1;
        case (state)
            ST_IDLE: begin
                success_d = 1'b0;
                if (vga_re) begin
                    state_d    = ST_READ;
                    cnt_d      = CNT_LOAD;
                    addr_d     = req_addr;
                    strobe_n_d = 1'b0;
                end
            end
            ST_READ: begin
                if (!vga_re) begin
                    state_d   = ST_IDLE;
                    success_d = 1'b0;
                end else if (cnt == 4'd0) begin
                    state_d   = ST_DONE;
                    data_d    = flash_d;
                    success_d = 1'b1;
                end else begin
                    cnt_d      = cnt - 4'd1;
                    strobe_n_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (!vga_re) begin
                    state_d   = ST_IDLE;
                    success_d = 1'b0;
                end else if (addr_moved) begin
                    // success was high during the cycle the move was seen; drop it now
                    state_d    = ST_READ;
                    cnt_d      = CNT_LOAD;
                    addr_d     = req_addr;
                    success_d  = 1'b0;
                    strobe_n_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                success_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            addr_q      <= 23'd0;
            vga_data    <= 16'd0;
            vga_success <= 1'b0;
            flash_ce_n  <= 1'b1;
            flash_oe_n  <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            addr_q      <= addr_d;
            vga_data    <= data_d;
            vga_success <= success_d;
            flash_ce_n  <= strobe_n_d;
            flash_oe_n  <= strobe_n_d;
        end
    end

    assign flash_a      = addr_q;
    assign dbg_state    = state;
    assign flash_we_n   = FLASH_WE_N_TIE;
    assign flash_rp_n   = FLASH_RP_N_TIE;
    assign flash_byte_n = FLASH_BYTE_N_TIE;
    assign flash_vpen   = FLASH_VPEN_TIE;

endmodule

// File: tb/tb_flash_img_reader.sv
// Directed bench for flash_img_reader: behavioural flash, consumer handshake,
// abort, mid-read reset and address change, and a stepping-consumer burst.
module tb_flash_img_reader;
    import vga_flash_pkg::*;

    localparam int BURST_WORDS = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_re;
    logic [22:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_success;
    logic [22:0] flash_a;
    wire  [15:0] flash_d;
    logic        flash_ce_n, flash_oe_n, flash_we_n;
    logic        flash_rp_n, flash_byte_n, flash_vpen;
    state_t      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    flash_img_reader #(.WAIT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_re      (vga_re),
        .vga_addr    (vga_addr),
        .vga_data    (vga_data),
        .vga_success (vga_success),
        .flash_a     (flash_a),
        .flash_d     (flash_d),
        .flash_ce_n  (flash_ce_n),
        .flash_oe_n  (flash_oe_n),
        .flash_we_n  (flash_we_n),
        .flash_rp_n  (flash_rp_n),
        .flash_byte_n(flash_byte_n),
        .flash_vpen  (flash_vpen),
        .dbg_state   (dbg_state)
    );

    // Pixel at byte address b; word 0 holds 16'hA55A, word 1 16'hA45B, word 2 16'hA758, word 4 16'hA15E.
    function automatic logic [7:0] pixel(input logic [22:0] b);
        return (b[0] ? 8'hA5 : 8'h5A) ^ b[8:1] ^ b[16:9];
    endfunction

    function automatic logic [15:0] flash_word(input logic [21:0] w);
        return {pixel({w, 1'b1}), pixel({w, 1'b0})};
    endfunction

    assign flash_d = (!flash_ce_n && !flash_oe_n) ? flash_word(flash_a[22:1]) : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advances from the launch edge until vga_success rises, recording strobe and success timing.
    task automatic run_read(output int lows, output int first_low, output int succ_cycle,
                            output logic succ_at1);
        lows       = 0;
        first_low  = -1;
        succ_cycle = -1;
        succ_at1   = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) succ_at1 = vga_success;
            if (!flash_ce_n && !flash_oe_n) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
            if (vga_success) begin
                succ_cycle = i;
                break;
            end
        end
    endtask

    int   lows, first_low, succ_cycle;
    logic succ_at1;
    logic rose;
    int   gap, min_gap, lows_total;
    logic got;

    initial begin
        rst      = 1'b0;
        vga_re   = 1'b1;
        vga_addr = 23'd0;

        repeat (3) begin
            tick();
            check("rst_ce_n", flash_ce_n, 1'b1);
            check("rst_oe_n", flash_oe_n, 1'b1);
        end
        check("rst_data", vga_data, 16'h0000);
        check("rst_success", vga_success, 1'b0);
        check("rst_flash_a", flash_a, 23'd0);
        check("rst_we_n", flash_we_n, 1'b1);
        check("rst_ties", {flash_rp_n, flash_byte_n, flash_vpen}, 3'b110);
        check("rst_state", dbg_state, ST_IDLE);

        // Single read of word 0
        rst = 1'b1;
        run_read(lows, first_low, succ_cycle, succ_at1);
        check("single_lows", lows, 4);
        check("single_first_low", first_low, 1);
        check("single_latency", succ_cycle, 5);
        check("single_data", vga_data, 16'hA55A);
        check("single_strobe_off", flash_ce_n, 1'b1);
        tick();
        check("hold_success", vga_success, 1'b1);
        check("hold_data", vga_data, 16'hA55A);
        check("hold_state", dbg_state, ST_DONE);

        // Handshake: step to word 1
        vga_addr = 23'd2;
        #1;
        check("hs_success_same_cycle", vga_success, 1'b1);
        run_read(lows, first_low, succ_cycle, succ_at1);
        check("hs_success_drop", succ_at1, 1'b0);
        check("hs_lows", lows, 4);
        check("hs_latency", succ_cycle, 5);
        check("hs_data", vga_data, 16'hA45B);
        check("hs_flash_a", flash_a, 23'd2);

        // Address moves mid-read: old word completes, then the new one is fetched
        vga_addr = 23'd4;
        tick();
        tick();
        vga_addr = 23'd8;
        tick();
        tick();
        tick();
        check("mid_old_success", vga_success, 1'b1);
        check("mid_old_data", vga_data, 16'hA758);
        run_read(lows, first_low, succ_cycle, succ_at1);
        check("mid_new_drop", succ_at1, 1'b0);
        check("mid_new_latency", succ_cycle, 5);
        check("mid_new_data", vga_data, 16'hA15E);

        // vga_re dropped in DONE
        vga_re = 1'b0;
        tick();
        check("done_drop_state", dbg_state, ST_IDLE);
        check("done_drop_success", vga_success, 1'b0);

        // Abort at READ cycle 2
        vga_addr = 23'h10;
        vga_re   = 1'b1;
        tick();
        tick();
        check("abort_strobe_low", flash_ce_n, 1'b0);
        vga_re = 1'b0;
        tick();
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_strobes", {flash_ce_n, flash_oe_n}, 2'b11);
        rose = vga_success;
        repeat (6) begin
            tick();
            rose = rose | vga_success;
        end
        check("abort_no_success", rose, 1'b0);
        check("abort_data_kept", vga_data, 16'hA15E);

        // Reset during READ
        vga_addr = 23'h20;
        vga_re   = 1'b1;
        tick();
        tick();
        check("rstmid_strobe_low", flash_oe_n, 1'b0);
        rst = 1'b0;
        tick();
        check("rstmid_strobes", {flash_ce_n, flash_oe_n}, 2'b11);
        check("rstmid_state", dbg_state, ST_IDLE);
        check("rstmid_data", vga_data, 16'h0000);
        check("rstmid_flash_a", flash_a, 23'd0);
        rst    = 1'b1;
        vga_re = 1'b0;
        tick();

        // Burst: consumer steps by 2 after each word it receives
        vga_addr   = 23'd0;
        vga_re     = 1'b1;
        min_gap    = 999;
        lows_total = 0;
        for (int w = 0; w < BURST_WORDS; w++) begin
            gap = 0;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                if (!flash_ce_n && !flash_oe_n) lows_total++;
                if (vga_success) got = 1'b1;
                else gap++;
            end
            if (!got) begin
                check("burst_timeout", got, 1'b1);
                break;
            end
            if (w > 0 && gap < min_gap) min_gap = gap;
            check("burst_word", vga_data, flash_word(w[21:0]));
            vga_addr = vga_addr + 23'd2;
        end
        check("burst_min_gap_ok", min_gap >= 4, 1'b1);
        check("burst_strobe_cycles", lows_total, 4 * BURST_WORDS);

        vga_re = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
